// File: rtl/ir_cmd_dispatch_pkg.sv
// Shared definitions for the IR command dispatcher: FSM states, default NEC remote codes,
// channel indices and a small index-width helper.
package ir_cmd_dispatch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [7:0] DEF_NEC_ADDR  = 8'h00;

  localparam logic [7:0] CODE_FWD      = 8'h18;
  localparam logic [7:0] CODE_BACK     = 8'h52;
  localparam logic [7:0] CODE_LEFT     = 8'h08;
  localparam logic [7:0] CODE_RIGHT    = 8'h5A;
  localparam logic [7:0] CODE_AUTO     = 8'h16;
  localparam logic [7:0] CODE_DANCE    = 8'h19;
  localparam logic [7:0] CODE_SHUTDOWN = 8'h0D;
  localparam logic [7:0] CODE_HEAD     = 8'h0C;
  localparam logic [7:0] CODE_FLASH    = 8'h5E;
  localparam logic [7:0] CODE_STOP     = 8'h45;

  localparam int CH_FWD      = 0;
  localparam int CH_BACK     = 1;
  localparam int CH_LEFT     = 2;
  localparam int CH_RIGHT    = 3;
  localparam int CH_AUTO     = 0;
  localparam int CH_DANCE    = 1;
  localparam int CH_SHUTDOWN = 2;
  localparam int CH_HEAD     = 3;
  localparam int CH_FLASH    = 4;

  // Channel i occupies bits [8i+7:8i], so the first-listed code sits at the MSB end.
  localparam logic [31:0] DEF_MOM_CODES = {CODE_RIGHT, CODE_LEFT, CODE_BACK, CODE_FWD};
  localparam logic [39:0] DEF_TOG_CODES = {CODE_FLASH, CODE_HEAD, CODE_SHUTDOWN, CODE_DANCE, CODE_AUTO};

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ir_cmd_dispatch_if.sv
// Decoded NEC frame stream plus the brake level, from the IR receiver side into the dispatcher.
// frame_valid and frame_repeat are single-cycle pulses with no back-pressure; there is no ready.
interface ir_cmd_dispatch_if;
  logic       frame_valid;
  logic [7:0] frame_addr;
  logic [7:0] frame_cmd;
  logic       frame_repeat;
  logic       brake_in;

  modport master (
    output frame_valid, frame_addr, frame_cmd, frame_repeat, brake_in
  );

  modport slave (
    input frame_valid, frame_addr, frame_cmd, frame_repeat, brake_in
  );
endinterface

// File: rtl/ir_cmd_dispatch_code_match.sv
// Combinational lookup of an 8-bit command in a packed code table; the lowest matching
// channel index wins when a code appears more than once.
module ir_code_match #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [7:0]     i_code,
  input  logic [N*8-1:0] i_code_table,
  output logic           o_hit,
  output logic [IW-1:0]  o_idx
);

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_code_table[8*i +: 8] == i_code) begin
        o_hit = 1'b1;
        o_idx = i[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ir_cmd_dispatch.sv
// Fans decoded NEC frames out to momentary drive channels (held by repeat codes, timed out
// otherwise) and latched toggle channels, with brake and stop override.
module ir_cmd_dispatch
  import ir_cmd_dispatch_pkg::*;
#(
  parameter int               CLK_HZ    = 100_000_000,
  parameter int               HOLD_MS   = 120,
  parameter int               NUM_MOM   = 4,
  parameter int               NUM_TOG   = 5,
  parameter logic [7:0]       NEC_ADDR  = DEF_NEC_ADDR,
  parameter logic [NUM_MOM*8-1:0] MOM_CODES = DEF_MOM_CODES,
  parameter logic [NUM_TOG*8-1:0] TOG_CODES = DEF_TOG_CODES,
  parameter logic [7:0]       STOP_CODE = CODE_STOP
) (
  input  logic               clk,
  input  logic               reset,
  ir_cmd_dispatch_if.slave   frm,
  output logic [NUM_MOM-1:0] mom_out,
  output logic [NUM_TOG-1:0] tog_out,
  output logic               stop_pulse,
  output logic               active,
  output logic [7:0]         last_cmd,
  output logic [7:0]         err_cnt,
  output state_e             dbg_state
);

  localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
  localparam int CW       = $clog2(HOLD_CYC + 1);
  localparam int MIW      = idx_w(NUM_MOM);
  localparam int TIW      = idx_w(NUM_TOG);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC);

  state_e             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_MOM-1:0] r_mom, w_mom_nxt;
  logic [NUM_TOG-1:0] r_tog, w_tog_nxt;
  logic               r_stop, w_stop_nxt;
  logic [7:0]         r_last, w_last_nxt;
  logic [7:0]         r_err, w_err_nxt;

  logic               w_mom_hit, w_tog_hit;
  logic [MIW-1:0]     w_mom_idx;
  logic [TIW-1:0]     w_tog_idx;
  logic               w_addr_ok, w_is_stop, w_mom_frame, w_tog_frame, w_known;
  logic [NUM_MOM-1:0] w_mom_onehot;
  logic [NUM_TOG-1:0] w_tog_onehot;

  ir_code_match #(.N(NUM_MOM), .IW(MIW)) u_mom_match (
    .i_code       (frm.frame_cmd),
    .i_code_table (MOM_CODES),
    .o_hit        (w_mom_hit),
    .o_idx        (w_mom_idx)
  );

  ir_code_match #(.N(NUM_TOG), .IW(TIW)) u_tog_match (
    .i_code       (frm.frame_cmd),
    .i_code_table (TOG_CODES),
    .o_hit        (w_tog_hit),
    .o_idx        (w_tog_idx)
  );

  // Priority: stop over momentary over toggle, all gated by the address check.
  assign w_addr_ok    = frm.frame_valid && (frm.frame_addr == NEC_ADDR);
  assign w_is_stop    = w_addr_ok && (frm.frame_cmd == STOP_CODE);
  assign w_mom_frame  = w_addr_ok && !w_is_stop && w_mom_hit;
  assign w_tog_frame  = w_addr_ok && !w_is_stop && !w_mom_hit && w_tog_hit;
  assign w_known      = w_is_stop || w_mom_frame || w_tog_frame;
  assign w_mom_onehot = NUM_MOM'(1) << w_mom_idx;
  assign w_tog_onehot = NUM_TOG'(1) << w_tog_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mom   <= '0;
      r_tog   <= '0;
      r_stop  <= 1'b0;
      r_last  <= 8'h00;
      r_err   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mom   <= w_mom_nxt;
      r_tog   <= w_tog_nxt;
      r_stop  <= w_stop_nxt;
      r_last  <= w_last_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mom_nxt   = r_mom;
    w_tog_nxt   = r_tog;
    w_stop_nxt  = 1'b0;
    w_last_nxt  = r_last;
    w_err_nxt   = r_err;

    if (frm.frame_valid && !w_known && (r_err != 8'hFF)) begin
      w_err_nxt = r_err + 8'd1;
    end
    if (w_known) begin
      w_last_nxt = frm.frame_cmd;
    end
    if (w_tog_frame) begin
      w_tog_nxt = r_tog ^ w_tog_onehot;
    end

    case (r_state)
      IDLE: begin
        if (w_mom_frame) begin
          w_mom_nxt   = w_mom_onehot;
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A full frame in the same cycle shadows any repeat pulse.
        if (w_mom_frame) begin
          w_mom_nxt = w_mom_onehot;
          w_cnt_nxt = HOLD_LD;
        end else if (frm.frame_repeat && !frm.frame_valid) begin
          w_cnt_nxt = HOLD_LD;
        end else if (r_cnt <= CW'(1)) begin
          w_mom_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_mom_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase

    if (w_is_stop || frm.brake_in) begin
      w_mom_nxt   = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = IDLE;
    end
    w_stop_nxt = w_is_stop;
  end

  assign mom_out    = r_mom;
  assign tog_out    = r_tog;
  assign stop_pulse = r_stop;
  assign active     = (r_state == HOLD);
  assign last_cmd   = r_last;
  assign err_cnt    = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ir_cmd_dispatch.sv
// Directed bench for ir_cmd_dispatch with a cycle-time drive model and literal spot checks.
module tb_ir_cmd_dispatch;
  import ir_cmd_dispatch_pkg::*;

  localparam int HOLD_CYC = 10;

  logic       clk;
  logic       reset;
  logic [3:0] mom_out;
  logic [4:0] tog_out;
  logic       stop_pulse;
  logic       active;
  logic [7:0] last_cmd;
  logic [7:0] err_cnt;
  state_e     dbg_state;

  int checks = 0;
  int errors = 0;

  ir_cmd_dispatch_if frm ();

  ir_cmd_dispatch #(
    .CLK_HZ  (10_000),
    .HOLD_MS (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frm        (frm),
    .mom_out    (mom_out),
    .tog_out    (tog_out),
    .stop_pulse (stop_pulse),
    .active     (active),
    .last_cmd   (last_cmd),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a drive lasts while the current cycle is within HOLD_CYC cycles of its last frame/repeat.
  logic [7:0] mom_codes [4] = '{8'h18, 8'h52, 8'h08, 8'h5A};
  logic [7:0] tog_codes [5] = '{8'h16, 8'h19, 8'h0D, 8'h0C, 8'h5E};
  int         cyc = 0;
  int         m_drive = -1;
  int         m_ev = 0;
  bit         model_valid = 1'b0;
  logic [3:0] exp_mom = '0;
  logic [4:0] exp_tog = '0;
  logic       exp_stop = 1'b0;
  logic [7:0] exp_last = '0;
  logic [7:0] exp_err = '0;

  always @(posedge clk) begin
    int mi, ti;
    if (reset) begin
      m_drive  = -1;
      exp_tog  = '0;
      exp_stop = 1'b0;
      exp_last = '0;
      exp_err  = '0;
    end else begin
      exp_stop = 1'b0;
      if (frm.frame_valid) begin
        mi = -1;
        ti = -1;
        for (int i = 0; i < 4; i++) if (mi < 0 && mom_codes[i] == frm.frame_cmd) mi = i;
        for (int i = 0; i < 5; i++) if (ti < 0 && tog_codes[i] == frm.frame_cmd) ti = i;
        if (frm.frame_addr != 8'h00 || (frm.frame_cmd != 8'h45 && mi < 0 && ti < 0)) begin
          exp_err = (exp_err == 8'd255) ? 8'd255 : exp_err + 8'd1;
        end else begin
          exp_last = frm.frame_cmd;
          if (frm.frame_cmd == 8'h45) begin
            m_drive  = -1;
            exp_stop = 1'b1;
          end else if (mi >= 0) begin
            m_drive = mi;
            m_ev    = cyc;
          end else begin
            exp_tog[ti] = ~exp_tog[ti];
          end
        end
      end else if (frm.frame_repeat && m_drive >= 0) begin
        m_ev = cyc;
      end
      if (m_drive >= 0 && cyc >= m_ev + HOLD_CYC) m_drive = -1;
      if (frm.brake_in) m_drive = -1;
    end
    exp_mom     = (m_drive >= 0) ? 4'(1 << m_drive) : 4'b0000;
    model_valid = 1'b1;
    cyc++;
  end

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      cmp("mom_out", int'(mom_out), int'(exp_mom));
      cmp("active", int'(active), (exp_mom != 0) ? 1 : 0);
      cmp("dbg_state", int'(dbg_state), (exp_mom != 0) ? 1 : 0);
      cmp("tog_out", int'(tog_out), int'(exp_tog));
      cmp("stop_pulse", int'(stop_pulse), int'(exp_stop));
      cmp("last_cmd", int'(last_cmd), int'(exp_last));
      cmp("err_cnt", int'(err_cnt), int'(exp_err));
    end
  end

  task automatic drive(input logic fv, input logic [7:0] addr, input logic [7:0] cmd, input logic rep);
    frm.frame_valid  = fv;
    frm.frame_addr   = addr;
    frm.frame_cmd    = cmd;
    frm.frame_repeat = rep;
    @(posedge clk);
    #1;
    frm.frame_valid  = 1'b0;
    frm.frame_repeat = 1'b0;
  endtask

  task automatic send(input logic [7:0] cmd);
    drive(1'b1, 8'h00, cmd, 1'b0);
  endtask

  task automatic send_rep();
    drive(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset            = 1'b1;
    frm.frame_valid  = 1'b0;
    frm.frame_addr   = 8'h00;
    frm.frame_cmd    = 8'h00;
    frm.frame_repeat = 1'b0;
    frm.brake_in     = 1'b0;
    idle(3);
    cmp("reset_mom", int'(mom_out), 0);
    cmp("reset_err", int'(err_cnt), 0);
    reset = 1'b0;
    idle(2);

    // 1: single fwd frame, held exactly HOLD_CYC cycles
    send(CODE_FWD);
    cmp("t1_fwd_on", int'(mom_out), 4'b0001);
    cmp("t1_active", int'(active), 1);
    idle(9);
    cmp("t1_last_cycle", int'(mom_out), 4'b0001);
    idle(1);
    cmp("t1_dropped", int'(mom_out), 0);
    cmp("t1_inactive", int'(active), 0);
    idle(3);

    // 2: repeats every 8 cycles keep the drive alive
    send(CODE_FWD);
    for (int k = 0; k < 3; k++) begin
      idle(7);
      send_rep();
    end
    idle(9);
    cmp("t2_held", int'(mom_out), 4'b0001);
    idle(1);
    cmp("t2_dropped", int'(mom_out), 0);
    idle(2);

    // 3: switch fwd -> left without a gap
    send(CODE_FWD);
    idle(3);
    send(CODE_LEFT);
    cmp("t3_left", int'(mom_out), 4'b0100);
    cmp("t3_last", int'(last_cmd), 8'h08);
    idle(12);

    // 4: headlight toggle, repeat ignored
    send(CODE_HEAD);
    cmp("t4_on", int'(tog_out), 5'b01000);
    send_rep();
    cmp("t4_rep", int'(tog_out), 5'b01000);
    send(CODE_HEAD);
    cmp("t4_off", int'(tog_out), 5'b00000);
    send(CODE_HEAD);
    idle(2);

    // 5: brake kills drive; momentary under brake not driven; stop pulse
    send(CODE_FWD);
    idle(2);
    frm.brake_in = 1'b1;
    idle(1);
    cmp("t5_brake", int'(mom_out), 0);
    send(CODE_RIGHT);
    cmp("t5_brake_mom", int'(mom_out), 0);
    cmp("t5_brake_last", int'(last_cmd), 8'h5A);
    frm.brake_in = 1'b0;
    idle(1);
    send(CODE_BACK);
    cmp("t5_back", int'(mom_out), 4'b0010);
    send(CODE_STOP);
    cmp("t5_stop", int'(stop_pulse), 1);
    cmp("t5_stop_mom", int'(mom_out), 0);
    cmp("t5_tog_kept", int'(tog_out), 5'b01000);
    idle(1);
    cmp("t5_stop_end", int'(stop_pulse), 0);
    send(8'hA7);
    cmp("t5_unknown", int'(err_cnt), 1);

    // frame and repeat in one cycle: repeat dropped, toggle frame keeps drive timing
    send(CODE_LEFT);
    idle(3);
    drive(1'b1, 8'h12, 8'h00, 1'b1);
    send(CODE_AUTO);
    idle(12);

    // 6: error saturation, then reset mid-hold
    for (int k = 0; k < 300; k++) drive(1'b1, 8'h12, CODE_FWD, 1'b0);
    cmp("t6_err_sat", int'(err_cnt), 255);
    cmp("t6_mom", int'(mom_out), 0);
    cmp("t6_tog", int'(tog_out), 5'b01001);
    send(CODE_FWD);
    idle(3);
    reset = 1'b1;
    idle(1);
    cmp("t6_rst_mom", int'(mom_out), 0);
    cmp("t6_rst_tog", int'(tog_out), 0);
    cmp("t6_rst_err", int'(err_cnt), 0);
    reset = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
